// File: rtl/param_memory_if.sv
// Request/response bus for param_memory: one shared address serves both
// the read and the write of a cycle.
interface param_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0]   address;
  logic                write;
  logic                read;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W/8-1:0] wr_be;
  logic                ready;
  logic [DATA_W-1:0]   data_out;
  logic                rd_valid;
  logic                dropped;

  modport master (
    output address, write, read, data_in, wr_be,
    input  ready, data_out, rd_valid, dropped
  );

  modport slave (
    input  address, write, read, data_in, wr_be,
    output ready, data_out, rd_valid, dropped
  );
endinterface

// File: rtl/param_memory.sv
// Single-port synchronous RAM with byte enables, a 1- or 2-stage read
// pipeline and a sequencer that zeroes every entry after reset.
module param_memory #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int RD_LATENCY = 1
) (
  input logic           clock,
  input logic           reset,
  param_memory_if.slave mem_bus
);
  // state   | meaning
  // ST_INIT | clearing one entry per edge; requests are dropped
  // ST_RUN  | serving read/write requests until the next reset

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                clr_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   merged;

  logic                s1_vld_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic                pipe_vld;
  logic [DATA_W-1:0]   pipe_data;

  logic                rd_valid_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                dropped_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign accept = (state_q == ST_RUN);
  assign wr_en  = accept && mem_bus.write;
  assign rd_en  = accept && mem_bus.read;

  // Write-first merge: doubles as the write word and the same-cycle read word.
  always_comb begin
    merged = mem_q[mem_bus.address];
    for (int b = 0; b < NB; b++) begin
      if (wr_en && mem_bus.wr_be[b]) begin
        merged[8*b +: 8] = mem_bus.data_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_en) begin
        mem_q[mem_bus.address] <= merged;
      end
    end
  end

  assign pipe_vld  = (RD_LATENCY == 2) ? s1_vld_q  : rd_en;
  assign pipe_data = (RD_LATENCY == 2) ? s1_data_q : merged;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
      dropped_q  <= 1'b0;
    end else begin
      s1_vld_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= merged;
      end
      rd_valid_q <= pipe_vld;
      if (pipe_vld) begin
        data_out_q <= pipe_data;
      end
      dropped_q <= !accept && (mem_bus.read || mem_bus.write);
    end
  end

  assign mem_bus.ready    = accept;
  assign mem_bus.rd_valid = rd_valid_q;
  assign mem_bus.data_out = data_out_q;
  assign mem_bus.dropped  = dropped_q;
endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: two instances (read latency 1 and 2) driven with
// identical stimulus and compared against a queue-based reference model.
module tb_param_memory;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  param_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  param_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  param_memory #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (bus1)
  );

  param_memory #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2)) dut2 (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (bus2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: contents, edges since release, pending reads with due cycle
  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  logic [15:0] mem_m [DEPTH];
  int          since_rel = 0;
  pend_t       pq1[$];
  pend_t       pq2[$];
  logic        v_m [2];
  logic [15:0] d_m [2];
  logic        rdy_m;
  logic        drop_m;

  typedef struct {
    logic        rst, rd, wr;
    logic [2:0]  a;
    logic [15:0] din;
    logic [1:0]  be;
    logic        e_rdy, e_vld, e_drop;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rst, input logic rd, input logic wr,
                            input logic [2:0] a, input logic [15:0] din, input logic [1:0] be);
    logic [15:0] w;
    pend_t p;
    cyc++;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0;
      since_rel = 0;
      pq1.delete();
      pq2.delete();
      v_m[0] = 1'b0; v_m[1] = 1'b0;
      d_m[0] = 16'h0; d_m[1] = 16'h0;
      drop_m = 1'b0;
    end else begin
      if (since_rel >= DEPTH) begin
        w = mem_m[a];
        if (wr) begin
          for (int b = 0; b < 2; b++) if (be[b]) w[8*b +: 8] = din[8*b +: 8];
          mem_m[a] = w;
        end
        if (rd) begin
          p.data = w;
          p.due  = cyc;
          pq1.push_back(p);
          p.due  = cyc + 1;
          pq2.push_back(p);
        end
        drop_m = 1'b0;
      end else begin
        drop_m = rd | wr;
        since_rel++;
      end
      v_m[0] = 1'b0;
      if (pq1.size() > 0 && pq1[0].due == cyc) begin
        p = pq1.pop_front();
        v_m[0] = 1'b1;
        d_m[0] = p.data;
      end
      v_m[1] = 1'b0;
      if (pq2.size() > 0 && pq2[0].due == cyc) begin
        p = pq2.pop_front();
        v_m[1] = 1'b1;
        d_m[1] = p.data;
      end
    end
    rdy_m = (since_rel >= DEPTH);
  endtask

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [2:0] a, input logic [15:0] din, input logic [1:0] be);
    reset         = rst;
    bus1.read     = rd;    bus2.read     = rd;
    bus1.write    = wr;    bus2.write    = wr;
    bus1.address  = a;     bus2.address  = a;
    bus1.data_in  = din;   bus2.data_in  = din;
    bus1.wr_be    = be;    bus2.wr_be    = be;
    @(posedge clock);
    model_step(rst, rd, wr, a, din, be);
    #1;
    chk("lat1_ready",    32'(bus1.ready),    32'(rdy_m));
    chk("lat1_rd_valid", 32'(bus1.rd_valid), 32'(v_m[0]));
    chk("lat1_data_out", 32'(bus1.data_out), 32'(d_m[0]));
    chk("lat1_dropped",  32'(bus1.dropped),  32'(drop_m));
    chk("lat2_ready",    32'(bus2.ready),    32'(rdy_m));
    chk("lat2_rd_valid", 32'(bus2.rd_valid), 32'(v_m[1]));
    chk("lat2_data_out", 32'(bus2.data_out), 32'(d_m[1]));
    chk("lat2_dropped",  32'(bus2.dropped),  32'(drop_m));
  endtask

  task automatic add(input logic rst, input logic rd, input logic wr, input logic [2:0] a,
                     input logic [15:0] din, input logic [1:0] be, input logic e_rdy,
                     input logic e_vld, input logic e_drop, input logic [15:0] e_dout);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.din = din; v.be = be;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_drop = e_drop; v.e_dout = e_dout;
    tbl.push_back(v);
  endtask

  initial begin
    // expectations below are for the RD_LATENCY=2 instance
    //   rst rd wr  a  din       be     rdy vld drp dout
    add(1, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 1, 3, 16'hDEAD, 2'b11, 0, 0, 1, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 3, 16'h0000, 2'b00, 1, 0, 0, 16'h0000);
    add(0, 0, 1, 5, 16'hA5C3, 2'b11, 1, 1, 0, 16'h0000);
    add(0, 1, 0, 5, 16'h0000, 2'b00, 1, 0, 0, 16'h0000);
    add(0, 0, 1, 5, 16'hFF00, 2'b01, 1, 1, 0, 16'hA5C3);
    add(0, 1, 0, 5, 16'h0000, 2'b00, 1, 0, 0, 16'hA5C3);
    add(0, 0, 1, 2, 16'h1234, 2'b11, 1, 1, 0, 16'hA500);
    add(0, 1, 1, 2, 16'hBEEF, 2'b10, 1, 0, 0, 16'hA500);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 1, 1, 0, 16'hBE34);
    add(0, 0, 1, 0, 16'h0011, 2'b11, 1, 0, 0, 16'hBE34);
    add(0, 0, 1, 1, 16'h0022, 2'b11, 1, 0, 0, 16'hBE34);
    add(0, 0, 1, 2, 16'h0033, 2'b11, 1, 0, 0, 16'hBE34);
    add(0, 1, 0, 0, 16'h0000, 2'b00, 1, 0, 0, 16'hBE34);
    add(0, 1, 0, 1, 16'h0000, 2'b00, 1, 1, 0, 16'h0011);
    add(0, 1, 0, 2, 16'h0000, 2'b00, 1, 1, 0, 16'h0022);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 1, 1, 0, 16'h0033);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 1, 0, 0, 16'h0033);
    add(0, 1, 0, 5, 16'h0000, 2'b00, 1, 0, 0, 16'h0033);
    add(1, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 5, 16'h0000, 2'b00, 1, 0, 1, 16'h0000);
    add(0, 1, 0, 5, 16'h0000, 2'b00, 1, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 2'b00, 1, 1, 0, 16'h0000);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].din, tbl[i].be);
      chk($sformatf("tbl%0d_ready", i),    32'(bus2.ready),    32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(bus2.rd_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_dropped", i),  32'(bus2.dropped),  32'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_data_out", i), 32'(bus2.data_out), 32'(tbl[i].e_dout));
    end

    // all entries read back zero after the clear
    for (int a = 0; a < DEPTH; a++) step(0, 1, 0, 3'(a), 16'h0, 2'b00);
    step(0, 0, 0, 0, 16'h0, 2'b00);
    step(0, 0, 0, 0, 16'h0, 2'b00);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        step(1, 0, 0, 0, 16'h0, 2'b00);
        if ($urandom_range(0, 1) == 1) step(1, 0, 0, 0, 16'h0, 2'b00);
      end else begin
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
